memc_deskew: RTL and testbench

Result-side counterpart of the skewed A-input feeder. It captures the diagonally skewed result stream leaving the bottom edge of the DIM×DIM systolic array and removes the skew with per-column delay lines. It then stores each completed result row in a DIM×DIM register file that the host reads by row index. It sits between the array's column outputs and the host read path, and signals when a full result matrix has landed.

---
 rtl/memc_deskew.sv | 111 +++++++++++
 tb/tb_memc_deskew.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/memc_deskew.sv
// rtl/memc_deskew.sv - removes diagonal skew from systolic array results and stores rows in a readable register file
module memc_deskew #(
    parameter int BITS_C = 16,
    parameter int DIM    = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic                           en,
    input  logic [DIM-1:0][BITS_C-1:0]     Cin,
    input  logic [$clog2(DIM)-1:0]         Crow,
    output logic [DIM-1:0][BITS_C-1:0]     Cout,
    output logic                           busy,
    output logic                           done
);

    localparam int CW = $clog2(2*DIM-1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_DONE
    } state_t;

    state_t                        state_q, state_d;
    logic [CW-1:0]                 count_q, count_d;
    logic                          step;
    logic [DIM-1:0][BITS_C-1:0]    aligned;
    logic [DIM-1:0][BITS_C-1:0]    row_q [DIM];

    assign step = (state_q == S_COLLECT) && en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_COLLECT;
                    count_d = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_COLLECT: begin
                if (en) begin
                    count_d = count_q + 1'b1;
                    if (count_q == CW'(2*DIM-2)) begin
                        state_d = S_DONE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Column c is delayed DIM-1-c steps so every element of a row lines up with column DIM-1
    for (genvar c = 0; c < DIM; c++) begin : g_col
        if (c == DIM-1) begin : g_direct
            assign aligned[c] = Cin[c];
        end else begin : g_dl
            localparam int LEN = DIM-1-c;
            logic [BITS_C-1:0] line_q [LEN];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int s = 0; s < LEN; s++) begin
                        line_q[s] <= '0;
                    end
                end else if (step) begin
                    line_q[0] <= Cin[c];
                    for (int s = 1; s < LEN; s++) begin
                        line_q[s] <= line_q[s-1];
                    end
                end
            end

            assign aligned[c] = line_q[LEN-1];
        end
    end

    // Row r completes when the count reaches r+DIM-1; earlier counts carry stale delay-line data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < DIM; r++) begin
                row_q[r] <= '0;
            end
        end else if (step) begin
            for (int r = 0; r < DIM; r++) begin
                if (count_q == CW'(r+DIM-1)) begin
                    row_q[r] <= aligned;
                end
            end
        end
    end

    assign Cout = row_q[Crow];
    assign busy = (state_q == S_COLLECT);
    assign done = (state_q == S_DONE);

endmodule

// File: tb/tb_memc_deskew.sv
// tb/tb_memc_deskew.sv - directed table-driven bench for memc_deskew with DIM=4, BITS_C=16
module tb_memc_deskew;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic              en;
    logic [3:0][15:0]  cin;
    logic [1:0]        crow;
    logic [3:0][15:0]  cout;
    logic              busy;
    logic              done;

    int checks;
    int errors;

    typedef struct {
        int          mode;
        int          crow;
        logic [63:0] exp;
    } vec_t;

    vec_t vec [12];

    memc_deskew #(.BITS_C(16), .DIM(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .en    (en),
        .Cin   (cin),
        .Crow  (crow),
        .Cout  (cout),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] cval(input int mode, input int k, input int c);
        int r;
        r = k - c;
        if (r < 0 || r > 3) return 16'hDEAD;
        case (mode)
            0:       return 16'(100*r + c);
            1:       return 16'(1000 + 100*r + c);
            default: return (((r + c) % 2) != 0) ? 16'h8000 : 16'hFFFF;
        endcase
    endfunction

    task automatic check_table(input int mode, input string tag);
        for (int i = 0; i < 12; i++) begin
            if (vec[i].mode == mode) begin
                crow = 2'(vec[i].crow);
                #1;
                check($sformatf("%s_row%0d", tag, vec[i].crow), cout, vec[i].exp);
            end
        end
    endtask

    task automatic check_zero_rows(input string tag);
        for (int r = 0; r < 4; r++) begin
            crow = 2'(r);
            #1;
            check($sformatf("%s_row%0d", tag, r), cout, 64'h0);
        end
    endtask

    // Called at #1 after a rising edge; drives one capture and observes it cycle by cycle.
    task automatic run_capture(input int mode, input int stall_a, input int stall_b,
                               input bit stop_at_done, input bit spur_start, input int abort_k,
                               output int done_cyc, output int done_cnt,
                               output logic busy1, output logic busy_at_done,
                               output logic [63:0] coll_old, output logic [63:0] coll_new);
        int k;
        int stall_rem;
        bit sa;
        bit sb;
        int got_old;
        start = 1'b1;
        en = 1'b0;
        crow = 2'd0;
        k = 0;
        stall_rem = 0;
        sa = 0;
        sb = 0;
        got_old = 0;
        done_cyc = -1;
        done_cnt = 0;
        busy1 = 1'b0;
        busy_at_done = 1'bx;
        coll_old = 'x;
        coll_new = 'x;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            @(posedge clk);
            #1;
            start = spur_start && (cyc == 3 || cyc == 6);
            if (got_old == 1) begin
                coll_new = cout;
                got_old = 2;
            end
            if (cyc == 1) busy1 = busy;
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc = cyc;
                    busy_at_done = busy;
                end
                if (stop_at_done) return;
            end
            if (k == abort_k) begin
                rst_n = 1'b0;
                return;
            end
            if (stall_rem == 0 && k == stall_a && !sa) begin
                sa = 1;
                stall_rem = 3;
            end
            if (stall_rem == 0 && k == stall_b && !sb) begin
                sb = 1;
                stall_rem = 3;
            end
            for (int c = 0; c < 4; c++) begin
                cin[c] = (k <= 6) ? cval(mode, k, c) : 16'hDEAD;
            end
            en = (k <= 6) && (stall_rem == 0);
            if (stall_rem > 0) stall_rem--;
            if (en && k == 3 && got_old == 0) begin
                coll_old = cout;
                got_old = 1;
            end
            if (en) k++;
        end
        start = 1'b0;
        en = 1'b0;
    endtask

    int          dcyc;
    int          dcnt;
    logic        b1;
    logic        bdone;
    logic [63:0] cold;
    logic [63:0] cnew;
    int          late_done;

    initial begin
        checks = 0;
        errors = 0;
        vec[0]  = '{0, 0, 64'h0003_0002_0001_0000};
        vec[1]  = '{0, 1, 64'h0067_0066_0065_0064};
        vec[2]  = '{0, 2, 64'h00CB_00CA_00C9_00C8};
        vec[3]  = '{0, 3, 64'h012F_012E_012D_012C};
        vec[4]  = '{1, 0, 64'h03EB_03EA_03E9_03E8};
        vec[5]  = '{1, 1, 64'h044F_044E_044D_044C};
        vec[6]  = '{1, 2, 64'h04B3_04B2_04B1_04B0};
        vec[7]  = '{1, 3, 64'h0517_0516_0515_0514};
        vec[8]  = '{2, 0, 64'h8000_FFFF_8000_FFFF};
        vec[9]  = '{2, 1, 64'hFFFF_8000_FFFF_8000};
        vec[10] = '{2, 2, 64'h8000_FFFF_8000_FFFF};
        vec[11] = '{2, 3, 64'hFFFF_8000_FFFF_8000};

        rst_n = 1'b0;
        start = 1'b0;
        en = 1'b0;
        crow = 2'd0;
        cin = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check_zero_rows("reset");
        check("reset_busy", 64'(busy), 64'h0);
        check("reset_done", 64'(done), 64'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_capture(0, -1, -1, 1'b0, 1'b0, -1, dcyc, dcnt, b1, bdone, cold, cnew);
        check("basic_done_cycle", 64'(dcyc), 64'd8);
        check("basic_done_count", 64'(dcnt), 64'd1);
        check("basic_busy_rise", 64'(b1), 64'h1);
        check("basic_busy_at_done", 64'(bdone), 64'h0);
        check("basic_collide_old", cold, 64'h0);
        check("basic_collide_new", cnew, 64'h0003_0002_0001_0000);
        check_table(0, "basic");

        run_capture(2, -1, -1, 1'b0, 1'b0, -1, dcyc, dcnt, b1, bdone, cold, cnew);
        check("signed_done_cycle", 64'(dcyc), 64'd8);
        check("signed_collide_old", cold, 64'h0003_0002_0001_0000);
        check("signed_collide_new", cnew, 64'h8000_FFFF_8000_FFFF);
        check_table(2, "signed");

        run_capture(0, 2, 5, 1'b0, 1'b0, -1, dcyc, dcnt, b1, bdone, cold, cnew);
        check("stall_done_cycle", 64'(dcyc), 64'd14);
        check("stall_done_count", 64'(dcnt), 64'd1);
        check_table(0, "stall");

        run_capture(2, -1, -1, 1'b1, 1'b0, -1, dcyc, dcnt, b1, bdone, cold, cnew);
        check("b2b_first_done_cycle", 64'(dcyc), 64'd8);
        run_capture(1, -1, -1, 1'b0, 1'b1, -1, dcyc, dcnt, b1, bdone, cold, cnew);
        check("b2b_busy_no_idle", 64'(b1), 64'h1);
        check("b2b_done_cycle", 64'(dcyc), 64'd8);
        check("b2b_done_count", 64'(dcnt), 64'd1);
        check_table(1, "b2b");

        run_capture(0, -1, -1, 1'b0, 1'b0, 5, dcyc, dcnt, b1, bdone, cold, cnew);
        #1;
        check_zero_rows("abort");
        check("abort_busy", 64'(busy), 64'h0);
        check("abort_done", 64'(done), 64'h0);
        en = 1'b1;
        start = 1'b0;
        late_done = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            if (done) late_done++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (done) late_done++;
        end
        check("abort_no_done", 64'(late_done), 64'h0);
        en = 1'b0;
        run_capture(2, -1, -1, 1'b0, 1'b0, -1, dcyc, dcnt, b1, bdone, cold, cnew);
        check("recover_done_cycle", 64'(dcyc), 64'd8);
        check("recover_done_count", 64'(dcnt), 64'd1);
        check_table(2, "recover");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
